// File: rtl/aoi_pkg.sv
// Shared mode definitions for the pipelined AND-OR-INVERT evaluator.
package aoi_pkg;

    localparam int unsigned ModeW = 2;

    typedef enum logic [ModeW-1:0] {
        ModeAoi = 2'b00,
        ModeAo  = 2'b01,
        ModeOai = 2'b10,
        ModeOa  = 2'b11
    } aoi_mode_e;

    // OR inside groups, AND across groups.
    function automatic logic is_or_first(input aoi_mode_e m);
        return m inside {ModeOai, ModeOa};
    endfunction

    // Final result is not inverted.
    function automatic logic is_true_out(input aoi_mode_e m);
        return m inside {ModeAo, ModeOa};
    endfunction

endpackage

// File: rtl/aoi_slice.sv
// One valid/ready register slice; loads when upstream is valid and it is empty or draining.
module aoi_slice
    import aoi_pkg::*;
#(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid_i,
    output logic             up_ready_o,
    input  logic [Width-1:0] up_data_i,
    output logic             dn_valid_o,
    input  logic             dn_ready_i,
    output logic [Width-1:0] dn_data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;
    logic             load;

    assign up_ready_o = !valid_q || dn_ready_i;
    assign load       = up_valid_i && up_ready_o;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = up_data_i;
        end else if (dn_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

endmodule

// File: rtl/aoi_pipe.sv
// Two-stage pipelined AND-OR-INVERT evaluator with per-beat mode and a saturating hit counter.
module aoi_pipe
    import aoi_pkg::*;
#(
    parameter int unsigned GROUP_SIZE = 2,
    parameter int unsigned NUM_GROUPS = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_GROUPS*GROUP_SIZE-1:0] in_x,
    input  logic [1:0]                       in_mode,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_GROUPS-1:0]            out_grp,
    output logic                             out_y,
    output logic [1:0]                       out_mode,
    input  logic                             cnt_clr,
    output logic [CNT_W-1:0]                 hit_cnt
);

    localparam int unsigned S1W = NUM_GROUPS + ModeW;
    localparam int unsigned S2W = NUM_GROUPS + ModeW + 1;

    aoi_mode_e             in_mode_e, s1_mode;
    logic [NUM_GROUPS-1:0] in_grp, s1_grp;
    logic [S1W-1:0]        s1_in_data, s1_data;
    logic [S2W-1:0]        s2_in_data, s2_data;
    logic                  s1_valid, s2_ready;
    logic                  red, y;
    logic [CNT_W-1:0]      hit_q, hit_d;

    assign in_mode_e = aoi_mode_e'(in_mode);

    always_comb begin
        in_grp = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            in_grp[g] = is_or_first(in_mode_e) ? |in_x[g*GROUP_SIZE +: GROUP_SIZE]
                                               : &in_x[g*GROUP_SIZE +: GROUP_SIZE];
        end
    end

    assign s1_in_data = {in_mode, in_grp};

    aoi_slice #(
        .Width(S1W)
    ) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .up_valid_i(in_valid),
        .up_ready_o(in_ready),
        .up_data_i (s1_in_data),
        .dn_valid_o(s1_valid),
        .dn_ready_i(s2_ready),
        .dn_data_o (s1_data)
    );

    assign s1_mode = aoi_mode_e'(s1_data[S1W-1 -: ModeW]);
    assign s1_grp  = s1_data[NUM_GROUPS-1:0];

    // Second-level reduction uses the mode carried with the beat, not the live input mode.
    assign red        = is_or_first(s1_mode) ? &s1_grp : |s1_grp;
    assign y          = is_true_out(s1_mode) ? red : ~red;
    assign s2_in_data = {s1_data[S1W-1 -: ModeW], s1_grp, y};

    aoi_slice #(
        .Width(S2W)
    ) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .up_valid_i(s1_valid),
        .up_ready_o(s2_ready),
        .up_data_i (s2_in_data),
        .dn_valid_o(out_valid),
        .dn_ready_i(out_ready),
        .dn_data_o (s2_data)
    );

    assign out_mode = s2_data[S2W-1 -: ModeW];
    assign out_grp  = s2_data[NUM_GROUPS:1];
    assign out_y    = s2_data[0];

    // Clear wins over a simultaneous hit; count holds at all-ones.
    always_comb begin
        hit_d = hit_q;
        if (cnt_clr) begin
            hit_d = '0;
        end else if (out_valid && out_ready && out_y && (hit_q != {CNT_W{1'b1}})) begin
            hit_d = hit_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_cnt = hit_q;

endmodule

// File: tb/tb_aoi_pipe.sv
// Scoreboard bench: default-sized instance with directed vectors, wide instance with a reference model.
module tb_aoi_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_y, a_cnt_clr;
    logic [3:0]  a_in_x;
    logic [1:0]  a_in_mode, a_out_grp, a_out_mode;
    logic [15:0] a_hit_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_y, b_cnt_clr;
    logic [11:0] b_in_x;
    logic [1:0]  b_in_mode, b_out_mode, b_hit_cnt;
    logic [3:0]  b_out_grp;

    int total = 0;
    int bad   = 0;
    logic [4:0] qa[$];
    logic [6:0] qb[$];
    logic sweep_on;

    logic [3:0] vx[8];
    logic [1:0] vm[8];
    logic [1:0] vg[8];
    logic       vy[8];

    aoi_pipe u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (a_in_valid),
        .in_ready (a_in_ready),
        .in_x     (a_in_x),
        .in_mode  (a_in_mode),
        .out_valid(a_out_valid),
        .out_ready(a_out_ready),
        .out_grp  (a_out_grp),
        .out_y    (a_out_y),
        .out_mode (a_out_mode),
        .cnt_clr  (a_cnt_clr),
        .hit_cnt  (a_hit_cnt)
    );

    aoi_pipe #(
        .GROUP_SIZE(3),
        .NUM_GROUPS(4),
        .CNT_W     (2)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_x     (b_in_x),
        .in_mode  (b_in_mode),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_grp  (b_out_grp),
        .out_y    (b_out_y),
        .out_mode (b_out_mode),
        .cnt_clr  (b_cnt_clr),
        .hit_cnt  (b_hit_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] model_b(input logic [11:0] x, input logic [1:0] m);
        logic [3:0] grp;
        logic       r;
        for (int g = 0; g < 4; g++) begin
            logic [2:0] bits;
            bits   = x[g*3 +: 3];
            grp[g] = m[1] ? (bits != 3'b000) : (bits == 3'b111);
        end
        r = m[1] ? (grp == 4'hf) : (grp != 4'h0);
        return {m, grp, (m[0] ? r : ~r)};
    endfunction

    task automatic at_mid();
        @(posedge clk);
        #1;
    endtask

    // Returns at the falling edge after the accepting edge.
    task automatic send_a(input logic [3:0] x, input logic [1:0] m, input logic [1:0] eg,
                          input logic ey);
        int n = 0;
        a_in_valid = 1'b1;
        a_in_x     = x;
        a_in_mode  = m;
        while (!a_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("a_accept_wait", 32'(n < 200), 1);
        qa.push_back({m, eg, ey});
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        a_in_x     = 4'hx;
    endtask

    task automatic send_b(input logic [11:0] x, input logic [1:0] m);
        int n = 0;
        b_in_valid = 1'b1;
        b_in_x     = x;
        b_in_mode  = m;
        while (!b_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b_accept_wait", 32'(n < 200), 1);
        qb.push_back(model_b(x, m));
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
    endtask

    task automatic drain_a();
        int n = 0;
        while ((qa.size() != 0 || a_out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("a_drain", qa.size(), 0);
    endtask

    task automatic drain_b();
        int n = 0;
        while ((qb.size() != 0 || b_out_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("b_drain", qb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("a_queue_nonempty", qa.size(), 1);
            else chk("a_out", {a_out_mode, a_out_grp, a_out_y}, qa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("b_queue_nonempty", qb.size(), 1);
            else chk("b_out", {b_out_mode, b_out_grp, b_out_y}, qb.pop_front());
        end
    end

    initial begin
        // x, mode, expected grp, expected y
        vx[0] = 4'b0011; vm[0] = 2'b00; vg[0] = 2'b01; vy[0] = 1'b0;
        vx[1] = 4'b0000; vm[1] = 2'b00; vg[1] = 2'b00; vy[1] = 1'b1;
        vx[2] = 4'b0101; vm[2] = 2'b10; vg[2] = 2'b11; vy[2] = 1'b0;
        vx[3] = 4'b0101; vm[3] = 2'b11; vg[3] = 2'b11; vy[3] = 1'b1;
        vx[4] = 4'b1100; vm[4] = 2'b01; vg[4] = 2'b10; vy[4] = 1'b1;
        vx[5] = 4'b1000; vm[5] = 2'b11; vg[5] = 2'b10; vy[5] = 1'b0;
        vx[6] = 4'b0000; vm[6] = 2'b10; vg[6] = 2'b00; vy[6] = 1'b1;
        vx[7] = 4'b1101; vm[7] = 2'b11; vg[7] = 2'b11; vy[7] = 1'b1;

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_x = '0; a_in_mode = '0; a_out_ready = 1'b0; a_cnt_clr = 1'b0;
        b_in_valid = 1'b0; b_in_x = '0; b_in_mode = '0; b_out_ready = 1'b0; b_cnt_clr = 1'b0;
        sweep_on = 1'b0;

        #12;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_grp", a_out_grp, 0);
        chk("rst_out_y", a_out_y, 0);
        chk("rst_out_mode", a_out_mode, 0);
        chk("rst_hit_cnt", a_hit_cnt, 0);
        at_mid();
        rst = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", a_in_ready, 1);

        // Latency on an empty pipe
        send_a(vx[0], vm[0], vg[0], vy[0]);
        chk("lat_s1_only", a_out_valid, 0);
        @(negedge clk);
        chk("lat_presented", a_out_valid, 1);
        drain_a();

        // Back-to-back beats with alternating modes
        for (int i = 0; i < 8; i++) send_a(vx[i], vm[i], vg[i], vy[i]);
        drain_a();

        // Clear counter, then stream all 8 under backpressure
        a_cnt_clr = 1'b1;
        @(negedge clk);
        a_cnt_clr = 1'b0;
        chk("clr_hit_cnt", a_hit_cnt, 0);
        at_mid();
        a_out_ready = 1'b0;
        send_a(vx[0], vm[0], vg[0], vy[0]);
        send_a(vx[1], vm[1], vg[1], vy[1]);
        chk("bp_in_ready_low", a_in_ready, 0);
        chk("bp_out_valid", a_out_valid, 1);
        chk("bp_held_grp", a_out_grp, vg[0]);
        fork
            begin
                for (int i = 2; i < 8; i++) send_a(vx[i], vm[i], vg[i], vy[i]);
            end
            begin
                repeat (3) @(posedge clk);
                #1 a_out_ready = 1'b1;
            end
        join
        drain_a();
        chk("hit_cnt_5", a_hit_cnt, 5);

        // Clear coincident with a y=1 transfer
        at_mid();
        a_out_ready = 1'b0;
        send_a(vx[3], vm[3], vg[3], vy[3]);
        @(negedge clk);
        chk("clr_beat_held", a_out_valid, 1);
        at_mid();
        a_out_ready = 1'b1;
        a_cnt_clr = 1'b1;
        at_mid();
        a_cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_priority", a_hit_cnt, 0);
        send_a(vx[1], vm[1], vg[1], vy[1]);
        drain_a();
        chk("hit_cnt_1", a_hit_cnt, 1);

        // Reset with both slices full
        at_mid();
        a_out_ready = 1'b0;
        send_a(vx[4], vm[4], vg[4], vy[4]);
        send_a(vx[7], vm[7], vg[7], vy[7]);
        chk("full_in_ready", a_in_ready, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", a_out_valid, 0);
        chk("mid_rst_hit_cnt", a_hit_cnt, 0);
        qa.delete();
        at_mid();
        rst = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", a_in_ready, 1);
        send_a(vx[2], vm[2], vg[2], vy[2]);
        chk("post_rst_s1_only", a_out_valid, 0);
        @(negedge clk);
        chk("post_rst_presented", a_out_valid, 1);
        drain_a();
        chk("post_rst_hit_cnt", a_hit_cnt, 0);

        // Saturation on the 2-bit counter
        b_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_b(12'h000, 2'b00);
        drain_b();
        chk("b_hit_sat", b_hit_cnt, 3);

        // Random sweep with random backpressure
        sweep_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 80; i++) send_b(12'($urandom), 2'($urandom_range(0, 3)));
                sweep_on = 1'b0;
            end
            begin
                while (sweep_on) begin
                    @(posedge clk);
                    #1 b_out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        at_mid();
        b_out_ready = 1'b1;
        @(negedge clk);
        drain_b();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
